// File: rtl/mix_columns_sequencer.sv
// mix_columns_sequencer: column-serial AES MixColumns with valid/ready handshakes and final-round bypass
module mix_columns_sequencer #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         i_clock,
   input  logic         i_reset,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [127:0] i_in_state,
   input  logic         i_in_inverse,
   input  logic         i_in_bypass,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [127:0] o_out_state,
   output logic         o_busy
);
   typedef enum logic [1:0] {IDLE, MIX, DONE} state_e;

   state_e       r_state, w_next;
   logic [127:0] r_work;
   logic [1:0]   r_col;
   logic         r_inv, r_out_valid, w_last;
   logic [31:0]  w_mixed [COLS_PER_CYCLE];

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("COLS_PER_CYCLE must be 1, 2 or 4");
   end

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // f0..f3 are the products for the four circulant coefficients (2 3 1 1 or 14 11 13 9)
   function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
      logic [7:0]  a, m2, m4, m8;
      logic [7:0]  f0 [4], f1 [4], f2 [4], f3 [4];
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         a     = c[8*i +: 8];
         m2    = xt(a);
         m4    = xt(m2);
         m8    = xt(m4);
         f0[i] = inv ? (m8 ^ m4 ^ m2) : m2;
         f1[i] = inv ? (m8 ^ m2 ^ a)  : (m2 ^ a);
         f2[i] = inv ? (m8 ^ m4 ^ a)  : a;
         f3[i] = inv ? (m8 ^ a)       : a;
      end
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = f0[i] ^ f1[2'(i + 1)] ^ f2[2'(i + 2)] ^ f3[2'(i + 3)];
      return r;
   endfunction

   for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_mix
      assign w_mixed[j] = mix(r_work[{r_col + 2'(j), 5'd0} +: 32], r_inv);
   end

   assign w_last      = r_col == 2'(4 - COLS_PER_CYCLE);
   assign o_in_ready  = r_state == IDLE && !i_reset;
   assign o_busy      = r_state != IDLE;
   assign o_out_valid = r_out_valid;
   assign o_out_state = r_work;

   // state register and registered result-valid flag
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= IDLE;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_out_valid <= w_next == DONE;
      end
   end

   // next-state: bypass jumps straight to DONE, mixing leaves after the last column group
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_in_valid) w_next = i_in_bypass ? DONE : MIX;
         MIX:     if (w_last) w_next = DONE;
         DONE:    if (i_out_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // working register: load on acceptance, then overwrite column groups in place
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_work <= '0;
         r_col  <= '0;
         r_inv  <= 1'b0;
      end else if (r_state == IDLE && i_in_valid) begin
         r_work <= i_in_state;
         r_col  <= '0;
         r_inv  <= i_in_inverse;
      end else if (r_state == MIX) begin
         for (int j = 0; j < COLS_PER_CYCLE; j++)
            r_work[{r_col + 2'(j), 5'd0} +: 32] <= w_mixed[j];
         r_col <= r_col + 2'(COLS_PER_CYCLE);
      end
   end
endmodule

// File: tb/tb_mix_columns_sequencer.sv
// tb_mix_columns_sequencer: directed checks of the MixColumns sequencer at 1, 2 and 4 columns per cycle
module tb_mix_columns_sequencer;
   logic         clk = 1'b0, rst = 1'b0;
   logic         in_valid = 1'b0, in_inverse = 1'b0, in_bypass = 1'b0, out_ready = 1'b1;
   logic [127:0] in_state = '0;
   logic         rdy1, ov1, bz1, rdy2, ov2, bz2, rdy4, ov4, bz4;
   logic [127:0] os1, os2, os4;
   logic [127:0] c_fi, c_fo, c_d4, c_d5, c_by;
   int           n_chk = 0, n_pass = 0;

   always #5 clk = ~clk;

   mix_columns_sequencer #(.COLS_PER_CYCLE(1)) dut1 (
      .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(rdy1), .i_in_state(in_state),
      .i_in_inverse(in_inverse), .i_in_bypass(in_bypass), .o_out_valid(ov1), .i_out_ready(out_ready),
      .o_out_state(os1), .o_busy(bz1));
   mix_columns_sequencer #(.COLS_PER_CYCLE(2)) dut2 (
      .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(rdy2), .i_in_state(in_state),
      .i_in_inverse(in_inverse), .i_in_bypass(in_bypass), .o_out_valid(ov2), .i_out_ready(out_ready),
      .o_out_state(os2), .o_busy(bz2));
   mix_columns_sequencer #(.COLS_PER_CYCLE(4)) dut4 (
      .i_clock(clk), .i_reset(rst), .i_in_valid(in_valid), .o_in_ready(rdy4), .i_in_state(in_state),
      .i_in_inverse(in_inverse), .i_in_bypass(in_bypass), .o_out_valid(ov4), .i_out_ready(out_ready),
      .o_out_state(os4), .o_busy(bz4));

   // written in reading order: leftmost hex pair is byte 0
   function automatic logic [127:0] bs(input logic [127:0] v);
      logic [127:0] r;
      for (int k = 0; k < 16; k++) r[8*k +: 8] = v[8*(15-k) +: 8];
      return r;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; in_bypass = 1'b0; out_ready = 1'b1;
      step;
      step;
      rst = 1'b0;
   endtask

   // presents a state for one edge, then flips the mode inputs to show they are not re-sampled
   task automatic accept(input logic [127:0] s, input logic inv, input logic byp);
      in_state = s; in_inverse = inv; in_bypass = byp; in_valid = 1'b1;
      step;
      in_valid = 1'b0; in_inverse = ~inv; in_bypass = 1'b0; in_state = ~s;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; in_state = c_fi;
      step;
      n_chk++; if (rdy1 !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", rdy1); else n_pass++;
      n_chk++; if (ov1 !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", ov1); else n_pass++;
      n_chk++; if (bz1 !== 1'b0) $display("FAIL rst_busy got %b exp 0", bz1); else n_pass++;
      n_chk++; if (os1 !== '0) $display("FAIL rst_out_state got %h exp 0", os1); else n_pass++;
      n_chk++; if ({ov2, bz2, ov4, bz4} !== 4'b0) $display("FAIL rst_sweep got %b exp 0000", {ov2, bz2, ov4, bz4}); else n_pass++;
      rst = 1'b0; in_valid = 1'b0;
      #1;
      n_chk++; if ({rdy1, rdy2, rdy4} !== 3'b111) $display("FAIL rst_release_ready got %b exp 111", {rdy1, rdy2, rdy4}); else n_pass++;
   endtask

   task automatic test_forward;
      do_reset;
      accept(c_fi, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) step;
         n_chk++; if (ov1 !== (k == 4)) $display("FAIL fwd_valid k=%0d got %b exp %b", k, ov1, k == 4); else n_pass++;
         if (k == 4) begin
            n_chk++; if (os1 !== c_fo) $display("FAIL fwd_state got %h exp %h", os1, c_fo); else n_pass++;
         end
      end
      n_chk++; if (rdy1 !== 1'b1 || bz1 !== 1'b0) $display("FAIL fwd_idle got rdy=%b busy=%b exp 1 0", rdy1, bz1); else n_pass++;
   endtask

   task automatic test_inverse;
      do_reset;
      accept(c_fo, 1'b1, 1'b0);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) step;
         n_chk++; if (ov1 !== (k == 4)) $display("FAIL inv_valid k=%0d got %b exp %b", k, ov1, k == 4); else n_pass++;
         if (k == 4) begin
            n_chk++; if (os1 !== c_fi) $display("FAIL inv_state got %h exp %h", os1, c_fi); else n_pass++;
         end
      end
   endtask

   task automatic test_bypass;
      do_reset;
      accept(c_by, 1'b0, 1'b1);
      n_chk++; if (ov1 !== 1'b1) $display("FAIL byp_valid got %b exp 1", ov1); else n_pass++;
      n_chk++; if (os1 !== c_by) $display("FAIL byp_state got %h exp %h", os1, c_by); else n_pass++;
      step;
      n_chk++; if (ov1 !== 1'b0 || rdy1 !== 1'b1) $display("FAIL byp_release got ov=%b rdy=%b exp 0 1", ov1, rdy1); else n_pass++;
      accept(c_fi, 1'b0, 1'b1);
      n_chk++; if (ov1 !== 1'b1 || os1 !== c_fi) $display("FAIL byp_back_to_back got ov=%b %h exp 1 %h", ov1, os1, c_fi); else n_pass++;
   endtask

   task automatic test_backpressure;
      do_reset;
      out_ready = 1'b0;
      accept(c_fi, 1'b0, 1'b0);
      for (int t = 0; t < 20 && !ov1; t++) step;
      n_chk++; if (ov1 !== 1'b1) $display("FAIL bp_wait_valid got %b exp 1", ov1); else n_pass++;
      in_state = c_fo; in_inverse = 1'b1; in_valid = 1'b1;
      for (int t = 0; t < 10; t++) begin
         step;
         n_chk++;
         if (ov1 !== 1'b1 || os1 !== c_fo || rdy1 !== 1'b0)
            $display("FAIL bp_hold t=%0d got ov=%b rdy=%b %h exp 1 0 %h", t, ov1, rdy1, os1, c_fo);
         else n_pass++;
      end
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      n_chk++; if (ov1 !== 1'b0 || rdy1 !== 1'b1) $display("FAIL bp_release got ov=%b rdy=%b exp 0 1", ov1, rdy1); else n_pass++;
      step;
      in_valid = 1'b0; in_inverse = 1'b0;
      n_chk++; if (bz1 !== 1'b1) $display("FAIL bp_second_taken got busy=%b exp 1", bz1); else n_pass++;
      for (int t = 0; t < 20 && !ov1; t++) step;
      n_chk++; if (ov1 !== 1'b1 || os1 !== c_fi) $display("FAIL bp_second_state got ov=%b %h exp 1 %h", ov1, os1, c_fi); else n_pass++;
      out_ready = 1'b1;
      step;
   endtask

   task automatic test_reset_mid_mix;
      do_reset;
      accept(c_fi, 1'b0, 1'b0);
      step;
      step;
      rst = 1'b1;
      step;
      rst = 1'b0;
      n_chk++; if (ov1 !== 1'b0 || bz1 !== 1'b0 || os1 !== '0) $display("FAIL mid_rst got ov=%b busy=%b %h exp 0 0 0", ov1, bz1, os1); else n_pass++;
      for (int t = 0; t < 6; t++) begin
         step;
         n_chk++; if (ov1 !== 1'b0) $display("FAIL mid_rst_no_valid t=%0d got %b exp 0", t, ov1); else n_pass++;
      end
      accept(c_d4, 1'b0, 1'b0);
      step;
      step;
      step;
      step;
      n_chk++; if (ov1 !== 1'b1 || os1 !== c_d5) $display("FAIL mid_rst_next got ov=%b %h exp 1 %h", ov1, os1, c_d5); else n_pass++;
   endtask

   task automatic test_sweep;
      do_reset;
      accept(c_fi, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step;
         n_chk++; if (ov2 !== (k == 2)) $display("FAIL sweep2_valid k=%0d got %b exp %b", k, ov2, k == 2); else n_pass++;
         n_chk++; if (ov4 !== (k == 1)) $display("FAIL sweep4_valid k=%0d got %b exp %b", k, ov4, k == 1); else n_pass++;
         if (k == 2) begin
            n_chk++; if (os2 !== c_fo) $display("FAIL sweep2_state got %h exp %h", os2, c_fo); else n_pass++;
         end
         if (k == 1) begin
            n_chk++; if (os4 !== c_fo) $display("FAIL sweep4_state got %h exp %h", os4, c_fo); else n_pass++;
         end
      end
   endtask

   initial begin
      c_fi = bs(128'hdb135345_f20a225c_01010101_2d26314c);
      c_fo = bs(128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
      c_d4 = bs(128'hd4d4d4d5_00000000_00000000_00000000);
      c_d5 = bs(128'hd5d5d7d6_00000000_00000000_00000000);
      c_by = 128'h0123456789abcdeffedcba9876543210;
      test_reset;
      test_forward;
      test_inverse;
      test_bypass;
      test_backpressure;
      test_reset_mid_mix;
      test_sweep;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mix_columns_sequencer.md
# mix_columns_sequencer

Column-serial MixColumns engine with valid/ready handshakes for area-constrained AES round datapaths. It accepts a 16-byte state and applies the forward or inverse MixColumns matrix, COLS_PER_CYCLE columns per clock, reusing a single bank of GF(2^8) column mixers. It sits between ShiftRows and AddRoundKey in an iterative round loop. A per-transaction bypass serves the final round, which has no MixColumns.

## Interface
- COLS_PER_CYCLE, default 1: number of columns mixed per clock; legal values are 1, 2 and 4. Any other value is an elaboration error.
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high.
- in_valid  input  1  upstream presents a state.
- in_ready  output  1  block can accept a state this cycle.
- in_state  input  state_t (128)  input state. Element k is byte k; column c = bytes 4c..4c+3, with row 0 first.
- in_inverse  input  1  0 selects the forward matrix (2 3 1 1 circulant); 1 selects the inverse (14 11 13 9 circulant).
- in_bypass  input  1  1 passes the state through unchanged (final round).
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_state  output  state_t (128)  result state.
- busy  output  1  high in any state other than IDLE.

## Operation
State machine: IDLE, MIX, DONE.
- IDLE
  - in_ready = 1.
  - On in_valid: latch in_state into the working register, and latch in_inverse and in_bypass into mode flags.
  - Clear the column counter col to 0.
  - Go to DONE if in_bypass = 1, otherwise go to MIX.
- MIX
  - Each cycle, columns col .. col+COLS_PER_CYCLE-1 of the working register are replaced with their mixed values.
  - The mixed values come from the latched mode (forward or inverse).
  - col increments by COLS_PER_CYCLE.
  - When the last column (3) is written, go to DONE.
  - Columns are updated in place. Unprocessed columns hold their input values.
- DONE
  - out_valid = 1 and out_state = working register.
  - Both are held stable while out_ready = 0.
  - On out_ready = 1, go to IDLE.
- Column math, per column (a0..a3):
  - Forward: b0 = 2a0^3a1^a2^a3, b1 = a0^2a1^3a2^a3, b2 = a0^a1^2a2^3a3, b3 = 3a0^a1^a2^2a3.
  - Inverse: b0 = 14a0^11a1^13a2^9a3, with rows rotated the same way as the forward case.
  - Multiplication is in GF(2^8) with reduction polynomial 0x11B. All results are 8 bits.
- in_inverse and in_bypass are sampled only at acceptance. Changes during MIX or DONE have no effect.
- in_ready = 0 in MIX and DONE. There is no overlap between transactions.
- in_valid in IDLE needs no qualification by out_ready.
- The col counter is 2 bits wide. With COLS_PER_CYCLE = 4, MIX lasts exactly one cycle.

## Timing
- Reset values:
  - state = IDLE.
  - in_ready = 1 from the first cycle after reset, except while reset itself is asserted, when in_ready = 0.
  - out_valid = 0, busy = 0.
  - Working register = 0, so out_state = 0.
  - col = 0, mode flags = 0.
- Acceptance edge is E0.
- Mixing latency: out_valid rises after edge E0 + 4/COLS_PER_CYCLE + 1.
  - COLS_PER_CYCLE = 1: out_valid is high in the 6th cycle after the accept cycle.
  - Bypass: out_valid is high the cycle after acceptance.
- Throughput, with out_ready held high:
  - One state every 4/COLS_PER_CYCLE + 2 cycles.
  - One state every 2 cycles in bypass.
- out_valid and out_state are registered. No combinational path from in_* to out_*.
- Reset asserted during MIX or DONE:
  - Aborts the transaction and discards the partial result.
  - out_valid is never asserted for the aborted state.
  - After reset, the block behaves exactly as after power-on.
- out_ready while out_valid = 0 is ignored.
- in_valid while in_ready = 0 is ignored. Upstream must hold the data.

## Test plan
- Forward, COLS_PER_CYCLE = 1:
  - Stimulus: columns db 13 53 45 | f2 0a 22 5c | 01 01 01 01 | 2d 26 31 4c, out_ready held at 1.
  - Required: out_state = 8e 4d a1 bc | 9f dc 58 9d | 01 01 01 01 | 4d 7e bd f8. out_valid is high for exactly one cycle, 5 edges after acceptance.
- Inverse:
  - Stimulus: the output of the forward test, with in_inverse = 1.
  - Required: the original input is reproduced exactly.
- Bypass:
  - Stimulus: in_bypass = 1, any state.
  - Required: out_state equals the input unchanged; out_valid is high one edge after acceptance.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles while in DONE, and drive in_valid with a second state.
  - Required: out_state and out_valid are stable, in_ready = 0, the second state is not taken. After out_ready pulses, the second state is accepted in the following IDLE cycle.
- Reset mid-MIX:
  - Stimulus: assert reset 2 cycles after acceptance.
  - Required: the next cycle shows out_valid = 0, busy = 0, out_state = 0. The following transaction with d4 d4 d4 d5 in column 0 yields d5 d5 d7 d6.
- Parameter sweep:
  - Stimulus: repeat the forward test with COLS_PER_CYCLE = 2 and 4.
  - Required: identical results, with latencies of 3 and 2 edges respectively.
